// File: rtl/lnic_net_rx_buffer.sv
// Receive-side store-and-forward packet buffer.
// The network endpoint pushes words with no backpressure; words land in a
// circular buffer behind a speculative write pointer and only become visible
// downstream once the packet's last word is committed. A packet that would
// overflow the buffer is rolled back and dropped in full.
// Optional build macro: LNIC_RX_BUF_DROP_CNT_EN implements the saturating
// drop_count register; without it drop_count is tied to zero.
//
// Handshake: a word moves on the output stream in any cycle where
// out_valid && out_ready are both high at the rising edge of clock; while
// out_valid is high and out_ready is low, out_bits_* hold steady. The input
// side has no ready: every net_in_valid word is either stored or dropped.
module lnic_net_rx_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              net_in_valid,
  input  logic [63:0]       net_in_bits_data,
  input  logic [7:0]        net_in_bits_keep,
  input  logic              net_in_bits_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_bits_data,
  output logic [7:0]        out_bits_keep,
  output logic              out_bits_last,
  output logic [ADDR_W:0]   pkt_count,
  output logic              drop_pulse,
  output logic [31:0]       drop_count
);

  typedef enum logic [0:0] {
    ST_ACCEPT = 1'b0,
    ST_DROP   = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);

  // FSM state; kept as a plainly named signal so checkers can bind to it
  state_t state_q;
  state_t state_d;

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] commit_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] used_cnt;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx;

  logic [63:0] mem_data [DEPTH];
  logic [7:0]  mem_keep [DEPTH];
  logic        mem_last [DEPTH];

  logic space;
  logic do_write;
  logic do_commit;
  logic do_drop;
  logic pop;
  logic pop_last;

  assign wr_idx   = wr_ptr[ADDR_W-1:0];
  assign rd_idx   = rd_ptr[ADDR_W-1:0];
  // Occupancy counts uncommitted words too, and uses rd_ptr from the start of
  // the cycle, so a pop in the same cycle does not make room.
  assign used_cnt = wr_ptr - rd_ptr;
  assign space    = (used_cnt < DEPTH_P);

  assign out_valid = (rd_ptr != commit_ptr);
  assign pop       = out_valid && out_ready;
  assign pop_last  = pop && mem_last[rd_idx];

  // Gated by out_valid so the outputs read as zero when nothing is presented
  // (in particular straight out of reset, before memory holds real data).
  assign out_bits_data = out_valid ? mem_data[rd_idx] : 64'd0;
  assign out_bits_keep = out_valid ? mem_keep[rd_idx] : 8'd0;
  assign out_bits_last = out_valid ? mem_last[rd_idx] : 1'b0;

  // Next-state and write/commit/drop decisions for the input side
  always_comb begin
    state_d   = state_q;
    do_write  = 1'b0;
    do_commit = 1'b0;
    do_drop   = 1'b0;
    case (state_q)
      ST_ACCEPT: begin
        if (net_in_valid) begin
          if (space) begin
            do_write  = 1'b1;
            do_commit = net_in_bits_last;
          end else begin
            do_drop = 1'b1;
            if (!net_in_bits_last) begin
              state_d = ST_DROP;
            end
          end
        end
      end
      ST_DROP: begin
        if (net_in_valid && net_in_bits_last) begin
          state_d = ST_ACCEPT;
        end
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_ACCEPT;
    end else begin
      state_q <= state_d;
    end
  end

  // Write, commit and read pointers; a drop rolls the write pointer back
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end else if (do_drop) begin
        wr_ptr <= commit_ptr;
      end
      if (do_commit) begin
        commit_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Buffer storage; contents need no reset because pointers guard visibility
  always_ff @(posedge clock) begin
    if (do_write) begin
      mem_data[wr_idx] <= net_in_bits_data;
      mem_keep[wr_idx] <= net_in_bits_keep;
      mem_last[wr_idx] <= net_in_bits_last;
    end
  end

  // Committed-packet count; simultaneous commit and last-pop cancel out
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_count <= '0;
    end else if (do_commit && !pop_last) begin
      pkt_count <= pkt_count + PTR_ONE;
    end else if (!do_commit && pop_last) begin
      pkt_count <= pkt_count - PTR_ONE;
    end
  end

  // One-cycle registered pulse for each dropped packet
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= do_drop;
    end
  end

`ifdef LNIC_RX_BUF_DROP_CNT_EN
  // Saturating count of dropped packets
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count <= 32'd0;
    end else if (do_drop && (drop_count != 32'hFFFF_FFFF)) begin
      drop_count <= drop_count + 32'd1;
    end
  end
`else
  assign drop_count = 32'd0;
`endif

endmodule

// File: tb/tb_lnic_net_rx_buffer.sv
// Directed testbench for lnic_net_rx_buffer (DEPTH=16).
// Inputs change 1ns after the rising edge; outputs are sampled at that same
// point, i.e. well away from the next active edge.
module tb_lnic_net_rx_buffer;

  logic        clock;
  logic        reset;
  logic        net_in_valid;
  logic [63:0] net_in_bits_data;
  logic [7:0]  net_in_bits_keep;
  logic        net_in_bits_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_bits_data;
  logic [7:0]  out_bits_keep;
  logic        out_bits_last;
  logic [4:0]  pkt_count;
  logic        drop_pulse;
  logic [31:0] drop_count;

  int errors = 0;
  int checks = 0;
  int exp_drops = 0;

  // Scoreboard: {data, keep, last} of every word expected downstream
  logic [72:0] exp_q[$];

  lnic_net_rx_buffer #(.DEPTH(16)) dut (
    .clock            (clock),
    .reset            (reset),
    .net_in_valid     (net_in_valid),
    .net_in_bits_data (net_in_bits_data),
    .net_in_bits_keep (net_in_bits_keep),
    .net_in_bits_last (net_in_bits_last),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_bits_data    (out_bits_data),
    .out_bits_keep    (out_bits_keep),
    .out_bits_last    (out_bits_last),
    .pkt_count        (pkt_count),
    .drop_pulse       (drop_pulse),
    .drop_count       (drop_count)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] word_data(input int id, input int idx);
    logic [31:0] hi;
    logic [31:0] lo;
    hi = id;
    lo = idx;
    return {hi ^ 32'hA5A5_0000, lo};
  endfunction

  function automatic logic [7:0] word_keep(input int idx, input int len);
    return (idx == len - 1) ? 8'h0F : 8'hFF;
  endfunction

  function automatic logic [31:0] exp_drop_count();
`ifdef LNIC_RX_BUF_DROP_CNT_EN
    return exp_drops;
`else
    return 32'd0;
`endif
  endfunction

  // Driver: put one word on the input bus for the next edge
  task automatic drive_word(input int id, input int idx, input int len);
    net_in_valid     = 1'b1;
    net_in_bits_data = word_data(id, idx);
    net_in_bits_keep = word_keep(idx, len);
    net_in_bits_last = (idx == len - 1);
  endtask

  task automatic idle_input();
    net_in_valid     = 1'b0;
    net_in_bits_data = '0;
    net_in_bits_keep = '0;
    net_in_bits_last = 1'b0;
  endtask

  // Driver: send a whole packet back to back; optionally expect it downstream
  task automatic send_pkt(input int id, input int len, input bit store);
    for (int i = 0; i < len; i++) begin
      drive_word(id, i, len);
      if (store) exp_q.push_back({word_data(id, i), word_keep(i, len), (i == len - 1)});
      tick();
    end
    idle_input();
  endtask

  // Drain n words with out_ready=1 and compare each against the scoreboard
  task automatic drain(input string name, input int n);
    int got;
    int cyc;
    logic [72:0] e;
    got = 0;
    cyc = 0;
    out_ready = 1'b1;
    while (got < n && cyc < 200) begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s: unexpected word %h, scoreboard empty", name, out_bits_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_bits_data, out_bits_keep, out_bits_last} !== e) begin
            errors++;
            $display("FAIL %s word %0d: got %h/%h/%b expected %h/%h/%b", name, got,
                     out_bits_data, out_bits_keep, out_bits_last, e[72:9], e[8:1], e[0]);
          end
        end
        got++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s count: got %0d words expected %0d", name, got, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_input();
    out_ready = 1'b0;
    tick();
    tick();
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    if ({out_bits_data, out_bits_keep, out_bits_last} !== 73'd0) begin
      errors++; $display("FAIL reset out_bits: got %h expected 0", {out_bits_data, out_bits_keep, out_bits_last});
    end
    if (pkt_count !== 5'd0) begin errors++; $display("FAIL reset pkt_count: got %0d expected 0", pkt_count); end
    if (drop_pulse !== 1'b0) begin errors++; $display("FAIL reset drop_pulse: got %b expected 0", drop_pulse); end
    if (drop_count !== 32'd0) begin errors++; $display("FAIL reset drop_count: got %0d expected 0", drop_count); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_word(1, i, 3);
      exp_q.push_back({word_data(1, i), word_keep(i, 3), (i == 2)});
      tick();
      checks++;
      if (out_valid !== (i == 2)) begin
        errors++; $display("FAIL basic out_valid after word %0d: got %b expected %b", i, out_valid, (i == 2));
      end
    end
    idle_input();
    checks++;
    if (pkt_count !== 5'd1) begin errors++; $display("FAIL basic pkt_count: got %0d expected 1", pkt_count); end
    drain("basic", 3);
    checks += 2;
    if (pkt_count !== 5'd0) begin errors++; $display("FAIL basic pkt_count end: got %0d expected 0", pkt_count); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic out_valid end: got %b expected 0", out_valid); end
  endtask

  task automatic test_overflow_small();
    out_ready = 1'b0;
    send_pkt(2, 8, 1'b1);
    send_pkt(3, 8, 1'b1);
    checks++;
    if (pkt_count !== 5'd2) begin errors++; $display("FAIL ovf pkt_count: got %0d expected 2", pkt_count); end
    send_pkt(4, 1, 1'b0);
    exp_drops++;
    checks += 3;
    if (drop_pulse !== 1'b1) begin errors++; $display("FAIL ovf drop_pulse: got %b expected 1", drop_pulse); end
    if (drop_count !== exp_drop_count()) begin
      errors++; $display("FAIL ovf drop_count: got %0d expected %0d", drop_count, exp_drop_count());
    end
    if (pkt_count !== 5'd2) begin errors++; $display("FAIL ovf pkt_count after drop: got %0d expected 2", pkt_count); end
    tick();
    checks++;
    if (drop_pulse !== 1'b0) begin errors++; $display("FAIL ovf drop_pulse width: got %b expected 0", drop_pulse); end
    drain("ovf", 16);
    checks += 2;
    if (pkt_count !== 5'd0) begin errors++; $display("FAIL ovf pkt_count end: got %0d expected 0", pkt_count); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf out_valid end: got %b expected 0", out_valid); end
  endtask

  task automatic test_long_packet();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_word(5, i, 20);
      tick();
      if (i == 16) begin
        checks++;
        if (drop_pulse !== 1'b1) begin errors++; $display("FAIL long drop_pulse at word 16: got %b expected 1", drop_pulse); end
      end
      if (i == 17) begin
        checks++;
        if (drop_pulse !== 1'b0) begin errors++; $display("FAIL long drop_pulse at word 17: got %b expected 0", drop_pulse); end
      end
    end
    idle_input();
    exp_drops++;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL long out_valid: got %b expected 0", out_valid); end
    if (pkt_count !== 5'd0) begin errors++; $display("FAIL long pkt_count: got %0d expected 0", pkt_count); end
    if (drop_count !== exp_drop_count()) begin
      errors++; $display("FAIL long drop_count: got %0d expected %0d", drop_count, exp_drop_count());
    end
    send_pkt(6, 2, 1'b1);
    checks++;
    if (pkt_count !== 5'd1) begin errors++; $display("FAIL long next pkt_count: got %0d expected 1", pkt_count); end
    drain("long_next", 2);
  endtask

  task automatic test_rollback();
    out_ready = 1'b0;
    send_pkt(7, 10, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive_word(8, i, 10);
      tick();
      if (i == 6) begin
        checks++;
        if (drop_pulse !== 1'b1) begin errors++; $display("FAIL rollback drop_pulse at word 7: got %b expected 1", drop_pulse); end
      end
    end
    idle_input();
    exp_drops++;
    checks += 2;
    if (pkt_count !== 5'd1) begin errors++; $display("FAIL rollback pkt_count: got %0d expected 1", pkt_count); end
    if (drop_count !== exp_drop_count()) begin
      errors++; $display("FAIL rollback drop_count: got %0d expected %0d", drop_count, exp_drop_count());
    end
    drain("rollback", 10);
    checks += 2;
    if (pkt_count !== 5'd0) begin errors++; $display("FAIL rollback pkt_count end: got %0d expected 0", pkt_count); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rollback out_valid end: got %b expected 0", out_valid); end
  endtask

  task automatic test_pop_same_cycle();
    logic [72:0] e;
    out_ready = 1'b0;
    send_pkt(9, 8, 1'b1);
    send_pkt(10, 8, 1'b1);
    // Buffer now full; pop the head while a 1-word packet arrives
    e = exp_q.pop_front();
    checks++;
    if ({out_bits_data, out_bits_keep, out_bits_last} !== e) begin
      errors++; $display("FAIL same_cycle popped word: got %h expected %h", out_bits_data, e[72:9]);
    end
    out_ready = 1'b1;
    drive_word(11, 0, 1);
    tick();
    out_ready = 1'b0;
    idle_input();
    exp_drops++;
    checks += 3;
    if (drop_pulse !== 1'b1) begin errors++; $display("FAIL same_cycle drop_pulse: got %b expected 1", drop_pulse); end
    if (pkt_count !== 5'd2) begin errors++; $display("FAIL same_cycle pkt_count: got %0d expected 2", pkt_count); end
    if (out_bits_data !== exp_q[0][72:9]) begin
      errors++; $display("FAIL same_cycle next head: got %h expected %h", out_bits_data, exp_q[0][72:9]);
    end
    drain("same_cycle", 15);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL same_cycle out_valid end: got %b expected 0", out_valid); end
    if (drop_count !== exp_drop_count()) begin
      errors++; $display("FAIL same_cycle drop_count: got %0d expected %0d", drop_count, exp_drop_count());
    end
  endtask

  task automatic test_reset_mid_packet();
    out_ready = 1'b0;
    send_pkt(12, 5, 1'b1);
    drive_word(13, 0, 4);
    tick();
    drive_word(13, 1, 4);
    tick();
    drive_word(13, 2, 4);
    reset = 1'b1;
    tick();
    idle_input();
    exp_q.delete();
    exp_drops = 0;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset out_valid: got %b expected 0", out_valid); end
    if (pkt_count !== 5'd0) begin errors++; $display("FAIL mid_reset pkt_count: got %0d expected 0", pkt_count); end
    if (drop_count !== 32'd0) begin errors++; $display("FAIL mid_reset drop_count: got %0d expected 0", drop_count); end
    reset = 1'b0;
    tick();
    send_pkt(14, 2, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_reset next out_valid: got %b expected 1", out_valid); end
    drain("mid_reset_next", 2);
    checks++;
    if (pkt_count !== 5'd0) begin errors++; $display("FAIL mid_reset pkt_count end: got %0d expected 0", pkt_count); end
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    idle_input();
    test_reset();
    test_basic();
    test_overflow_small();
    test_long_packet();
    test_rollback();
    test_pop_same_cycle();
    test_reset_mid_packet();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard leftover: got %0d words expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
